// File: rtl/pps_counter_gen.sv
// PPS edge counter and period monitor on a free-running system clock.
// Synchronises raw pps, counts its edges, times and qualifies the interval.
module pps_counter_gen #(
    parameter int          CNT_W       = 24,
    parameter int          PER_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter bit          WRAP        = 1'b1,
    parameter int unsigned MIN_PER     = 99_990_000,
    parameter int unsigned MAX_PER     = 100_010_000
) (
    input  logic             clk,
    input  logic             nclr,
    input  logic             pps,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] pcnt,
    output logic [PER_W-1:0] period,
    output logic             per_vld,
    output logic             pps_ok,
    output logic             lost,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOST
    } state_t;

    localparam logic [PER_W-1:0] MIN_V = PER_W'(MIN_PER);
    localparam logic [PER_W-1:0] MAX_V = PER_W'(MAX_PER);
    localparam logic [PER_W-1:0] ONE_V = PER_W'(1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;
    logic                   rise;
    logic [PER_W-1:0]       per_cnt;
    logic [PER_W-1:0]       per_inc;
    logic                   in_rng;

    assign rise    = sync[SYNC_STAGES-1] & ~dly;
    assign per_inc = (&per_cnt) ? per_cnt : per_cnt + ONE_V;
    assign in_rng  = (per_cnt >= MIN_V) && (per_cnt <= MAX_V);

    // Metastability chain plus edge-detect delay; deliberately ignores clr
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync[0] <= pps;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            dly <= sync[SYNC_STAGES-1];
        end
    end

    // Edge counter: wraps or saturates at all-ones, flagging ovf either way
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            pcnt <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            pcnt <= '0;
            ovf  <= 1'b0;
        end else if (rise && en) begin
            if (&pcnt) begin
                ovf <= 1'b1;
                if (WRAP) begin
                    pcnt <= '0;
                end
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Period FSM: arm on first edge, measure later edges, time out to LOST
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            state   <= IDLE;
            per_cnt <= '0;
            period  <= '0;
            per_vld <= 1'b0;
            pps_ok  <= 1'b0;
            lost    <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            per_cnt <= '0;
            period  <= '0;
            per_vld <= 1'b0;
            pps_ok  <= 1'b0;
            lost    <= 1'b0;
        end else begin
            per_vld <= 1'b0;
            per_cnt <= per_inc;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= RUN;
                        per_cnt <= ONE_V;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period  <= per_cnt;
                        per_cnt <= ONE_V;
                        per_vld <= 1'b1;
                        pps_ok  <= in_rng;
                    end else if (per_cnt > MAX_V) begin
                        state  <= LOST;
                        lost   <= 1'b1;
                        pps_ok <= 1'b0;
                    end
                end
                LOST: begin
                    if (rise) begin
                        state   <= RUN;
                        period  <= per_cnt;
                        per_cnt <= ONE_V;
                        per_vld <= 1'b1;
                        pps_ok  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
